// File: rtl/load_pkg.sv
// Shared definitions for the load unit: opcodes, FSM states, word width
// and small decode helpers used by load_unit and load_align.
package load_pkg;

   localparam int WORD_W = 32;

   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      MEM   = 3'd2,
      WB    = 3'd3,
      FAULT = 3'd4
   } state_t;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LW)  || (op == OP_LH) || (op == OP_LHU) ||
             (op == OP_LB)  || (op == OP_LBU);
   endfunction

   // Words need 4-byte alignment, halfwords 2-byte; bytes never fault.
   function automatic logic misaligned(input logic [5:0] op,
                                       input logic [1:0] a);
      logic m;
      m = 1'b0;
      unique case (1'b1)
         (op == OP_LW):                   m = (a != 2'b00);
         (op == OP_LH) || (op == OP_LHU): m = a[0];
         default:                         m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the byte/halfword lane of a little-endian word
// and sign- or zero-extends it.
// Ports: mem_rdata (raw word), addr (low address bits), opcode, data (result).
module load_align
   import load_pkg::*;
(
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic [1:0]        addr,
   input  logic [5:0]        opcode,
   output logic [WORD_W-1:0] data
);

   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   always_comb begin
      half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      byte_sel = mem_rdata[7:0];
      unique case (addr)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         2'd3:    byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
   end

   always_comb begin
      data = mem_rdata;
      unique case (1'b1)
         (opcode == OP_LH):  data = {{16{half_sel[15]}}, half_sel};
         (opcode == OP_LHU): data = {16'h0000, half_sel};
         (opcode == OP_LB):  data = {{24{byte_sel[7]}}, byte_sel};
         (opcode == OP_LBU): data = {24'h000000, byte_sel};
         default:            data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle MIPS load unit: address gen, memory read handshake, align, writeback.
// Ports: clk/reset, instruction/instr_valid/instr_ready, Read_data1 (base),
//   ALU_result/MemRead/mem_rdata/mem_ready (memory), RegWrite/Write_register/
//   Write_data (regfile), addr_error/done (status).
// Optional: define LOAD_TIMEOUT_EN to fault a read after TIMEOUT_CYCLES in MEM.
module load_unit
   import load_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instruction,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       Read_data1,
   output logic [31:0]       ALU_result,
   output logic              MemRead,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              RegWrite,
   output logic [4:0]        Write_register,
   output logic [31:0]       Write_data,
   output logic              addr_error,
   output logic              done
);

   state_t state, state_n;

   logic [5:0]        op_q;
   logic [4:0]        rt_q;
   logic [31:0]       base_q;
   logic [15:0]       off_q;
   logic [31:0]       eff_addr;
   logic [WORD_W-1:0] aligned;
   logic              accept;
   logic              to_hit;

   // rs is consumed upstream as Read_data1; its field is not needed here.
   logic unused_rs;
   assign unused_rs = ^instruction[25:21];

   assign accept   = (state == IDLE) && instr_valid &&
                     is_load(instruction[31:26]);
   assign eff_addr = base_q + {{16{off_q[15]}}, off_q};

`ifdef LOAD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] to_cnt;

   // Counter is zeroed while in ADDR so each MEM visit starts fresh.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if (state == ADDR) begin
         to_cnt <= '0;
      end else if ((state == MEM) && !mem_ready) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign to_hit = (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_CYCLES;
   assign to_hit     = 1'b0;
`endif

   load_align u_align (
      .mem_rdata (mem_rdata),
      .addr      (ALU_result[1:0]),
      .opcode    (op_q),
      .data      (aligned)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n     = state;
      instr_ready = 1'b0;
      MemRead     = 1'b0;
      RegWrite    = 1'b0;
      addr_error  = 1'b0;
      done        = 1'b0;
      unique case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (accept) begin
               state_n = ADDR;
            end
         end
         ADDR: begin
            state_n = misaligned(op_q, eff_addr[1:0]) ? FAULT : MEM;
         end
         MEM: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               state_n = WB;
            end else if (to_hit) begin
               state_n = FAULT;
            end
         end
         WB: begin
            RegWrite = (Write_register != 5'd0);
            done     = 1'b1;
            state_n  = IDLE;
         end
         FAULT: begin
            addr_error = 1'b1;
            done       = 1'b1;
            state_n    = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q           <= '0;
         rt_q           <= '0;
         base_q         <= '0;
         off_q          <= '0;
         ALU_result     <= '0;
         Write_data     <= '0;
         Write_register <= '0;
      end else begin
         if (accept) begin
            op_q   <= instruction[31:26];
            rt_q   <= instruction[20:16];
            off_q  <= instruction[15:0];
            base_q <= Read_data1;
         end
         if (state == ADDR) begin
            ALU_result <= eff_addr;
         end
         // Destination is published only with real data, so a fault
         // leaves the previous writeback values untouched.
         if ((state == MEM) && mem_ready) begin
            Write_data     <= aligned;
            Write_register <= rt_q;
         end
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Directed scoreboard bench for load_unit: expected writebacks are queued
// when a load is issued and compared when done pulses.
module tb_load_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] Read_data1;
   logic [31:0] ALU_result;
   logic        MemRead;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        RegWrite;
   logic [4:0]  Write_register;
   logic [31:0] Write_data;
   logic        addr_error;
   logic        done;

   always #5 clk = ~clk;

   load_unit dut (
      .clk            (clk),
      .reset          (reset),
      .instruction    (instruction),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .Read_data1     (Read_data1),
      .ALU_result     (ALU_result),
      .MemRead        (MemRead),
      .mem_rdata      (mem_rdata),
      .mem_ready      (mem_ready),
      .RegWrite       (RegWrite),
      .Write_register (Write_register),
      .Write_data     (Write_data),
      .addr_error     (addr_error),
      .done           (done)
   );

   typedef struct {
      logic        rw;
      logic        err;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [31:0] alu;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op,
                                      input logic [4:0] rt,
                                      input logic [15:0] off);
      return {op, 5'd4, rt, off};
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("RegWrite", {31'd0, RegWrite}, {31'd0, e.rw});
            check("addr_error", {31'd0, addr_error}, {31'd0, e.err});
            check("ALU_result", ALU_result, e.alu);
            if (!e.err) begin
               check("Write_register", {27'd0, Write_register},
                     {27'd0, e.wreg});
               check("Write_data", Write_data, e.wdata);
            end
         end
      end
   end

   task automatic do_load(input string tag, input logic [31:0] instr,
                          input logic [31:0] base, input logic [31:0] rdata,
                          input int delay, input logic [31:0] exp_alu,
                          input logic [31:0] exp_wdata, input logic exp_err,
                          input int exp_lat, input int exp_mr);
      exp_t e;
      int   mr;
      int   cyc_done;
      bit   seen;
      e.rw    = !exp_err && (instr[20:16] != 5'd0);
      e.err   = exp_err;
      e.wreg  = instr[20:16];
      e.wdata = exp_wdata;
      e.alu   = exp_alu;
      sb.push_back(e);
      instruction = instr;
      Read_data1  = base;
      instr_valid = 1'b1;
      @(negedge clk);
      check({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instruction = $urandom;
      Read_data1  = $urandom;
      mr       = 0;
      seen     = 0;
      cyc_done = -1;
      for (int c = 0; c < 60; c++) begin
         mem_ready = MemRead && (mr == delay);
         mem_rdata = mem_ready ? rdata : $urandom;
         if (MemRead) mr++;
         @(negedge clk);
         if (done) begin
            seen     = 1;
            cyc_done = c;
            break;
         end
         @(posedge clk);
         #1;
      end
      mem_ready = 1'b0;
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      check({tag, "_latency"}, cyc_done, exp_lat);
      check({tag, "_memread_cycles"}, mr, exp_mr);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      instruction = '0;
      instr_valid = 1'b0;
      Read_data1  = '0;
      mem_rdata   = '0;
      mem_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
      check("rst_MemRead", {31'd0, MemRead}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ALU_result", ALU_result, 32'd0);
      check("rst_Write_data", Write_data, 32'd0);
      check("rst_Write_register", {27'd0, Write_register}, 32'd0);
      @(posedge clk);
      #1;

      do_load("lw", mk(6'b100011, 5'd9, 16'h0004), 32'h0, 32'h12345678,
              0, 32'h4, 32'h12345678, 1'b0, 2, 1);
      do_load("lb", mk(6'b100000, 5'd10, 16'h0003), 32'h1C, 32'hABCDEF01,
              0, 32'h1F, 32'hFFFFFFAB, 1'b0, 2, 1);
      do_load("lbu", mk(6'b100100, 5'd10, 16'h0003), 32'h1C, 32'hABCDEF01,
              2, 32'h1F, 32'h000000AB, 1'b0, 4, 3);
      do_load("lh", mk(6'b100001, 5'd11, 16'h0002), 32'h20, 32'h80017FFF,
              0, 32'h22, 32'hFFFF8001, 1'b0, 2, 1);
      do_load("lhu", mk(6'b100101, 5'd11, 16'h0002), 32'h20, 32'h80017FFF,
              1, 32'h22, 32'h00008001, 1'b0, 3, 2);
      do_load("lh_lo", mk(6'b100001, 5'd12, 16'h0000), 32'h40, 32'h80017FFF,
              0, 32'h40, 32'h00007FFF, 1'b0, 2, 1);
      do_load("lb_lane1", mk(6'b100000, 5'd13, 16'h0000), 32'h1, 32'h00007F00,
              0, 32'h1, 32'h0000007F, 1'b0, 2, 1);
      do_load("lw_wrap", mk(6'b100011, 5'd14, 16'hFFFC), 32'h0, 32'h55AA55AA,
              0, 32'hFFFFFFFC, 32'h55AA55AA, 1'b0, 2, 1);
      do_load("lw_mis", mk(6'b100011, 5'd9, 16'h0002), 32'h1C, 32'h0,
              0, 32'h1E, 32'h0, 1'b1, 1, 0);
      do_load("lh_mis", mk(6'b100001, 5'd9, 16'h0000), 32'h21, 32'h0,
              0, 32'h21, 32'h0, 1'b1, 1, 0);
      do_load("rt0", mk(6'b100011, 5'd0, 16'h0010), 32'h40, 32'hCAFEF00D,
              5, 32'h50, 32'hCAFEF00D, 1'b0, 7, 6);

      instruction = mk(6'b101011, 5'd7, 16'h0008);
      Read_data1  = 32'h100;
      instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("sw_ignored_ready", {31'd0, instr_ready}, 32'd1);
         check("sw_ignored_memread", {31'd0, MemRead}, 32'd0);
         check("sw_ignored_alu", ALU_result, 32'h50);
         @(posedge clk);
         #1;
      end
      instr_valid = 1'b0;

`ifdef LOAD_TIMEOUT_EN
      do_load("timeout", mk(6'b100011, 5'd5, 16'h0000), 32'h100, 32'h0,
              1000, 32'h100, 32'h0, 1'b1, 17, 16);
`endif

      instruction = mk(6'b100011, 5'd6, 16'h0008);
      Read_data1  = 32'h200;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_memread", {31'd0, MemRead}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_memread", {31'd0, MemRead}, 32'd0);
      check("mid_rst_regwrite", {31'd0, RegWrite}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_addr_error", {31'd0, addr_error}, 32'd0);
      check("mid_rst_alu", ALU_result, 32'd0);
      check("mid_rst_wdata", Write_data, 32'd0);
      check("mid_rst_wreg", {27'd0, Write_register}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", {31'd0, instr_ready}, 32'd1);

      do_load("lbu_after_rst", mk(6'b100100, 5'd3, 16'h0001), 32'h10,
              32'h11223344, 0, 32'h11, 32'h00000033, 1'b0, 2, 1);

      check("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Multi-cycle load execution block for the MIPS execution-cycle datapath; it is the read-side counterpart of the store path.
- Accepts lw/lh/lhu/lb/lbu instructions and computes the effective address (base + sign-extended offset).
- Issues a memory read with a ready handshake.
- Aligns and extends the returned data, then pulses a register-file writeback.

Parameters:
TIMEOUT_CYCLES, 16, max cycles MemRead may wait for mem_ready (used only when LOAD_TIMEOUT_EN is defined)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
instruction  input  32  I-type word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:0] offset
instr_valid  input  1  instruction present
instr_ready  output  1  block idle and able to accept
Read_data1  input  32  base register value (rs), sampled at accept
ALU_result  output  32  registered effective address
MemRead  output  1  memory read request
mem_rdata  input  32  little-endian word at {ALU_result[31:2],2'b00}
mem_ready  input  1  mem_rdata valid this cycle
RegWrite  output  1  one-cycle writeback strobe
Write_register  output  5  destination rt
Write_data  output  32  aligned/extended load result
addr_error  output  1  one-cycle misalignment/timeout flag
done  output  1  one-cycle completion pulse (success or fault)

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - ALU_result, Write_data and Write_register clear to 0.
  - MemRead, RegWrite, addr_error and done clear to 0.
  - instr_ready = 1 once reset is released.
  - A load that is in flight is abandoned with no writeback.
- States: IDLE, ADDR, MEM, WB, FAULT.
- IDLE:
  - instr_ready = 1.
  - An instruction is accepted when instr_valid=1 and the opcode is one of 100011 (lw), 100001 (lh), 100101 (lhu), 100000 (lb), 100100 (lbu).
  - On accept, latch the opcode, rt and Read_data1, then go to ADDR.
  - Any other opcode is ignored: stay in IDLE, no outputs change.
- ADDR (1 cycle):
  - ALU_result <= base + {{16{off[15]}},off], wrapping modulo 2^32.
  - Misaligned access (lw with addr[1:0]!=0; lh/lhu with addr[0]!=0) goes to FAULT; otherwise go to MEM.
- MEM:
  - MemRead = 1 and ALU_result is held stable.
  - Stay in MEM until mem_ready=1; on that cycle capture the aligned data and go to WB.
  - MemRead deasserts in the cycle after mem_ready.
- Data alignment:
  - lw: full word.
  - lh/lhu: lane addr[1] selects the halfword ([15:0] or [31:16]).
  - lb/lbu: lane addr[1:0] selects mem_rdata[8k+7:8k].
  - lh/lb sign-extend the selected field; lhu/lbu zero-extend it.
- WB (1 cycle):
  - Write_data and Write_register are valid.
  - RegWrite = 1 unless rt == 0, in which case RegWrite stays 0 and Write_data still updates.
  - done = 1.
  - Go to IDLE.
- FAULT (1 cycle):
  - addr_error = 1 and done = 1.
  - No MemRead, no RegWrite.
  - Go to IDLE.
- Latency: accept at cycle N; ALU_result valid at N+1; MemRead from N+2. If mem_ready arrives at N+2+k, RegWrite/done occur at N+3+k. Minimum accept-to-writeback latency is 3 cycles.
- instr_ready is 0 in every state except IDLE, so back-to-back loads are spaced at least 4 cycles.
- Write_data, Write_register and ALU_result hold their last values in IDLE.
- mem_ready is ignored outside MEM.

Optional Feature:
LOAD_TIMEOUT_EN
- Defined: a counter runs in MEM. If mem_ready has not arrived after TIMEOUT_CYCLES cycles with MemRead high, go to FAULT (addr_error=1, done=1, no writeback). The counter clears on entering MEM.
- Undefined: MEM waits indefinitely and no counter logic exists.

Decomposition:
- Package load_pkg:
  - opcode constants OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU.
  - state enum/localparams IDLE, ADDR, MEM, WB, FAULT.
  - width constant WORD_W=32.
- Sub-module load_align (combinational): inputs mem_rdata, addr[1:0], opcode; output 32-bit aligned/extended value.

Test Plan:
- lw: instruction 100011_00100_01001_0000000000000100, Read_data1=0x00000000, mem_ready on the first MEM cycle with mem_rdata=0x12345678 -> ALU_result=0x00000004, Write_register=9, Write_data=0x12345678, RegWrite pulses 3 cycles after accept.
- lb/lbu: instruction 100000_00100_01010_0000000000000011, Read_data1=0x0000001C, mem_rdata=0xABCDEF01 -> ALU_result=0x1F, Write_data=0xFFFFFFAB. Same with opcode 100100 -> 0x000000AB.
- lh: offset 0x0002, Read_data1=0x20, mem_rdata=0x8001_7FFF -> Write_data=0xFFFF8001. lhu -> 0x00008001.
- Misaligned: lw with Read_data1=0x1C, offset 0x0002 -> addr_error=1, done=1 at accept+2, MemRead never asserted, RegWrite=0.
- rt=0 with mem_ready delayed 5 cycles -> MemRead held high for 6 cycles, RegWrite=0, done=1. Next, a non-load opcode 101011 with instr_valid=1 -> ignored, instr_ready stays 1.
- Reset asserted while in MEM -> all outputs 0 in the same cycle with no RegWrite. With LOAD_TIMEOUT_EN and mem_ready held low -> addr_error after 16 MEM cycles.
